// File: rtl/one_hot_to_bin_dec.sv
// Registered one-hot to binary decoder with valid/ready on both sides and one held output entry.
// Define ONEHOT_ERR_CNT_EN to add the saturating err_cnt_o counter of errored words accepted.
module one_hot_to_bin_dec #(
    parameter int BIN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2**BIN_W-1:0]   one_hot_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [BIN_W-1:0]      bin_o,
    output logic                  err_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
`ifdef ONEHOT_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]      err_cnt_o
`endif
);

    localparam int OH_W = 2**BIN_W;
    localparam logic [OH_W-1:0] OH_ONE = OH_W'(1);

    if (BIN_W < 1 || CNT_W < 1) begin : g_bad_param
        $error("one_hot_to_bin_dec: BIN_W and CNT_W must be at least 1");
    end

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             err_q, err_d;
    logic             accept, consume;
    logic [BIN_W-1:0] dec_bin;
    logic             dec_err;

    // Scan from the top so the last hit wins, leaving the lowest set bit's index.
    function automatic logic [BIN_W-1:0] lowest_idx(input logic [OH_W-1:0] x);
        logic [BIN_W-1:0] idx;
        idx = '0;
        for (int i = OH_W - 1; i >= 0; i--) begin
            if (x[i]) idx = BIN_W'(i);
        end
        return idx;
    endfunction

    function automatic logic not_one_hot(input logic [OH_W-1:0] x);
        return (x == '0) || ((x & (x - OH_ONE)) != '0);
    endfunction

    assign out_valid_o = (state_q == FULL);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;
    assign consume     = out_valid_o && out_ready_i;
    assign dec_bin     = lowest_idx(one_hot_i);
    assign dec_err     = not_one_hot(one_hot_i);
    assign bin_o       = bin_q;
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        err_d   = err_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (consume && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            bin_d = dec_bin;
            err_d = dec_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

`ifdef ONEHOT_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturate at all-ones; only reset brings the count back down.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule
